pc_ras_unit: RTL and testbench

- Parametrised program-counter register for the single-cycle/multi-cycle CPU datapath; successor to the plain enable/reset PC register.
- Computes next PC internally: sequential, branch, jump, call and return.
- Holds a circular return-address stack (RAS) of configurable depth, plus an executed-instruction counter for the debug/statistics display.

---
 rtl/pc_ras_unit.sv | 131 +++++++++++++
 tb/tb_pc_ras_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection, circular return-address stack
// and executed-instruction counter.
module pc_ras_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int unsigned STEP      = 1,
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned COUNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               branch,
   input  logic [WIDTH-1:0]   branch_target,
   input  logic               jump,
   input  logic               call,
   input  logic [WIDTH-1:0]   jump_target,
   input  logic               ret,
   output logic [WIDTH-1:0]   pc,
   output logic [WIDTH-1:0]   pc_plus,
   output logic               ras_empty,
   output logic               ras_full,
   output logic               ras_overflow,
   output logic               ras_underflow,
   output logic               conflict,
   output logic [COUNT_W-1:0] instr_count
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0]   pc_q, pc_d;
   logic [PTR_W-1:0]   sp_q, sp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
   logic [WIDTH-1:0]   ras_d [RAS_DEPTH];
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               cfl_q, cfl_d;
   logic [COUNT_W-1:0] icnt_q, icnt_d;

   logic [PTR_W-1:0]   sp_dec;
   logic               is_empty;
   logic               is_full;

   assign pc_plus  = pc_q + WIDTH'(STEP);
   assign sp_dec   = sp_q - PTR_W'(1);
   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == FULL_CNT);

   // Next-state selection: ret > call > jump > branch > sequential.
   // sp points at the next free slot; a push while full lands on the
   // oldest entry because the pointer wraps around the ring.
   always_comb begin
      pc_d   = pc_q;
      sp_d   = sp_q;
      cnt_d  = cnt_q;
      ras_d  = ras_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      cfl_d  = cfl_q;
      icnt_d = icnt_q;
      if (en) begin
         icnt_d = icnt_q + COUNT_W'(1);
         if (call && ret) begin
            cfl_d = 1'b1;
         end
         if (ret) begin
            if (is_empty) begin
               pc_d  = pc_plus;
               unf_d = 1'b1;
            end else begin
               pc_d  = ras_q[sp_dec];
               sp_d  = sp_dec;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end else if (call) begin
            pc_d        = jump_target;
            ras_d[sp_q] = pc_plus;
            sp_d        = sp_q + PTR_W'(1);
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (jump) begin
            pc_d = jump_target;
         end else if (branch) begin
            pc_d = branch_target;
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   // State registers with synchronous reset; stack contents need no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_VEC;
         sp_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         cfl_q  <= 1'b0;
         icnt_q <= '0;
      end else begin
         pc_q   <= pc_d;
         sp_q   <= sp_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
         cfl_q  <= cfl_d;
         icnt_q <= icnt_d;
      end
   end

   // Return-address storage.
   always_ff @(posedge clk) begin
      ras_q <= ras_d;
   end

   assign pc            = pc_q;
   assign ras_empty     = is_empty;
   assign ras_full      = is_full;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
   assign conflict      = cfl_q;
   assign instr_count   = icnt_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed testbench for pc_ras_unit: sequencing, priority, RAS
// nesting, overflow, underflow, conflict and wrap-around.
module tb_pc_ras_unit;

   logic        clk = 1'b0;
   logic        rst, en, branch, jump, call, ret;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc, pc_plus;
   logic        ras_empty, ras_full, ras_overflow, ras_underflow, conflict;
   logic [31:0] instr_count;

   logic        rst2, en2;
   logic        zero1;
   logic [31:0] zero32;
   logic [31:0] pc2, pc_plus2;
   logic        e2, f2, o2, u2, c2;
   logic [1:0]  icnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_ras_unit dut (
      .clk(clk), .rst(rst), .en(en),
      .branch(branch), .branch_target(branch_target),
      .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
      .pc(pc), .pc_plus(pc_plus),
      .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
      .conflict(conflict), .instr_count(instr_count)
   );

   pc_ras_unit #(.RESET_VEC(32'hFFFF_FFFE), .COUNT_W(2)) dut2 (
      .clk(clk), .rst(rst2), .en(en2),
      .branch(zero1), .branch_target(zero32),
      .jump(zero1), .call(zero1), .jump_target(zero32), .ret(zero1),
      .pc(pc2), .pc_plus(pc_plus2),
      .ras_empty(e2), .ras_full(f2),
      .ras_overflow(o2), .ras_underflow(u2),
      .conflict(c2), .instr_count(icnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 0; en = 0; branch = 0; jump = 0; call = 0; ret = 0;
      branch_target = '0; jump_target = '0;
   endtask

   // one clock edge, then settle outputs
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle(); rst = 1; tick(); rst = 0;
   endtask

   task automatic adv(input int n);
      idle(); en = 1;
      for (int i = 0; i < n; i++) tick();
      en = 0;
   endtask

   initial begin
      zero1 = 0; zero32 = '0; rst2 = 1; en2 = 0;
      idle();
      #2;

      // sequential / stall / reset
      do_reset();
      chk("rst_pc", pc, 32'h0);
      chk("rst_empty", {31'b0, ras_empty}, 32'h1);
      chk("rst_full", {31'b0, ras_full}, 32'h0);
      chk("rst_icnt", instr_count, 32'h0);
      chk("rst_flags", {29'b0, ras_overflow, ras_underflow, conflict}, 32'h0);
      chk("pc_plus0", pc_plus, 32'h1);
      en = 1; tick(); chk("seq1", pc, 32'h1);
      tick(); chk("seq2", pc, 32'h2);
      tick(); chk("seq3", pc, 32'h3);
      en = 0; jump = 1; jump_target = 32'h55; call = 1;
      tick(); chk("stall1", pc, 32'h3);
      tick(); chk("stall2", pc, 32'h3);
      chk("stall_empty", {31'b0, ras_empty}, 32'h1);
      idle(); en = 1;
      tick(); chk("seq4", pc, 32'h4);
      chk("icnt4", instr_count, 32'h4);
      en = 0; rst = 1; tick(); rst = 0;
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_icnt", instr_count, 32'h0);

      // priority
      adv(5);
      chk("pc5", pc, 32'h5);
      idle(); en = 1; branch = 1; branch_target = 32'h40;
      jump = 1; jump_target = 32'h80;
      tick(); chk("prio_jump", pc, 32'h80);
      jump = 0;
      tick(); chk("prio_branch", pc, 32'h40);

      // call / return nesting
      idle(); en = 1; jump = 1; jump_target = 32'h10;
      tick(); chk("to10", pc, 32'h10);
      idle(); en = 1; call = 1; jump_target = 32'h100;
      tick(); chk("call1", pc, 32'h100);
      jump_target = 32'h200;
      tick(); chk("call2", pc, 32'h200);
      idle(); en = 1; ret = 1;
      tick(); chk("ret1", pc, 32'h101);
      tick(); chk("ret2", pc, 32'h11);
      chk("nest_empty", {31'b0, ras_empty}, 32'h1);
      chk("nest_flags", {29'b0, ras_overflow, ras_underflow, conflict}, 32'h0);

      // overflow
      do_reset();
      idle(); en = 1; call = 1;
      for (int i = 1; i <= 5; i++) begin
         jump_target = 32'(i * 16);
         tick();
      end
      chk("ovf_pc", pc, 32'h50);
      chk("ovf_flag", {31'b0, ras_overflow}, 32'h1);
      chk("ovf_full", {31'b0, ras_full}, 32'h1);
      idle(); en = 1; ret = 1;
      tick(); chk("ovf_ret1", pc, 32'h41);
      tick(); chk("ovf_ret2", pc, 32'h31);
      tick(); chk("ovf_ret3", pc, 32'h21);
      tick(); chk("ovf_ret4", pc, 32'h11);
      chk("ovf_empty", {31'b0, ras_empty}, 32'h1);
      chk("ovf_nounf", {31'b0, ras_underflow}, 32'h0);

      // underflow / conflict
      do_reset();
      adv(7);
      chk("pc7", pc, 32'h7);
      idle(); en = 1; ret = 1;
      tick(); chk("unf_pc", pc, 32'h8);
      chk("unf_flag", {31'b0, ras_underflow}, 32'h1);
      idle(); en = 1; jump = 1; jump_target = 32'h32;
      tick();
      idle(); en = 1; call = 1; jump_target = 32'h90;
      tick(); chk("pre_cfl", pc, 32'h90);
      chk("pre_cfl_empty", {31'b0, ras_empty}, 32'h0);
      idle(); en = 1; call = 1; ret = 1; jump_target = 32'hA0;
      tick(); chk("cfl_pc", pc, 32'h33);
      chk("cfl_empty", {31'b0, ras_empty}, 32'h1);
      chk("cfl_flag", {31'b0, conflict}, 32'h1);
      chk("unf_sticky", {31'b0, ras_underflow}, 32'h1);
      do_reset();
      chk("clr_flags", {29'b0, ras_overflow, ras_underflow, conflict}, 32'h0);

      // wrap instance
      rst2 = 1; @(posedge clk); #1; rst2 = 0;
      chk("w_pc0", pc2, 32'hFFFF_FFFE);
      en2 = 1;
      @(posedge clk); #1; chk("w_pc1", pc2, 32'hFFFF_FFFF);
      chk("w_plus", pc_plus2, 32'h0);
      @(posedge clk); #1; chk("w_pc2", pc2, 32'h0);
      @(posedge clk); #1; chk("w_pc3", pc2, 32'h1);
      chk("w_icnt3", {30'b0, icnt2}, 32'h3);
      @(posedge clk); #1; chk("w_icnt0", {30'b0, icnt2}, 32'h0);
      en2 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
